// File: rtl/sigmoid_grad_if.sv
// rtl/sigmoid_grad_if.sv - stream/control bundle for the sigmoid backward-pass pipeline
interface sigmoid_grad_if #(
   parameter int WIDTH = 32
) ();
   logic             en;
   logic             valid_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] y;
   logic             valid_out;
   logic [15:0]      sample_cnt;

   modport master (
      output en, valid_in, a, g,
      input  y, valid_out, sample_cnt
   );

   modport slave (
      input  en, valid_in, a, g,
      output y, valid_out, sample_cnt
   );
endinterface

// File: rtl/sigmoid_grad.sv
// rtl/sigmoid_grad.sv - 3-stage Q8.24 sigmoid gradient d = g*y*(1-y)
// SIGMOID_GRAD_ROUND_EN selects round-half-up at both shifts; default truncates.
module sigmoid_grad #(
   parameter int WIDTH = 32,
   parameter int FL    = 24
) (
   input  logic          clk,
   input  logic          rst,
   sigmoid_grad_if.slave bus
);
   localparam logic [WIDTH-1:0]   ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FL;
`ifdef SIGMOID_GRAD_ROUND_EN
   localparam logic [2*WIDTH-1:0] RND = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FL-1);
`else
   localparam logic [2*WIDTH-1:0] RND = '0;
`endif

   logic [WIDTH-1:0]   ya_q, om_q, g1_q, p_q, g2_q, y_q;
   logic               v1_q, v2_q, vout_q;
   logic [15:0]        cnt_q;
   logic [WIDTH-1:0]   ya_d;
   logic [2*WIDTH-1:0] prod2, prod3;
   logic               unused_bits;

   // Negative inputs clamp to 0; anything above 1.0 clamps to ONE.
   always_comb begin
      ya_d = bus.a;
      if (bus.a[WIDTH-1])
         ya_d = '0;
      else if (bus.a > ONE)
         ya_d = ONE;
   end

   assign prod2 = ({{WIDTH{1'b0}}, ya_q} * {{WIDTH{1'b0}}, om_q}) + RND;
   // p is non-negative and far below 2^(WIDTH-1), so zero-extension keeps it positive.
   assign prod3 = ({{WIDTH{g2_q[WIDTH-1]}}, g2_q} * {{WIDTH{1'b0}}, p_q}) + RND;

   assign unused_bits = ^{prod2[2*WIDTH-1:FL+WIDTH], prod2[FL-1:0],
                          prod3[2*WIDTH-1:FL+WIDTH], prod3[FL-1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ya_q   <= '0;
         om_q   <= '0;
         g1_q   <= '0;
         v1_q   <= 1'b0;
         p_q    <= '0;
         g2_q   <= '0;
         v2_q   <= 1'b0;
         y_q    <= '0;
         vout_q <= 1'b0;
         cnt_q  <= '0;
      end else if (bus.en) begin
         ya_q   <= ya_d;
         om_q   <= ONE - ya_d;
         g1_q   <= bus.g;
         v1_q   <= bus.valid_in;
         p_q    <= prod2[FL+WIDTH-1:FL];
         g2_q   <= g1_q;
         v2_q   <= v1_q;
         y_q    <= prod3[FL+WIDTH-1:FL];
         vout_q <= v2_q;
         if (v2_q)
            cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.y          = y_q;
   assign bus.valid_out  = vout_q;
   assign bus.sample_cnt = cnt_q;
endmodule

// File: tb/tb_sigmoid_grad.sv
// tb/tb_sigmoid_grad.sv - scoreboard bench for sigmoid_grad
module tb_sigmoid_grad;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [15:0] prev_cnt = '0;

   sigmoid_grad_if #(.WIDTH(32)) bus ();
   sigmoid_grad #(.WIDTH(32), .FL(24)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

`ifdef SIGMOID_GRAD_ROUND_EN
   localparam longint RND = 64'sd1 << 23;
`else
   localparam longint RND = 0;
`endif
   localparam longint ONE_L = 64'sd1 << 24;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] gv);
      longint ya, p, d;
      ya = longint'($signed(av));
      if (ya < 0) ya = 0;
      if (ya > ONE_L) ya = ONE_L;
      p = (ya * (ONE_L - ya) + RND) >>> 24;
      d = (longint'($signed(gv)) * p + RND) >>> 24;
      return d[31:0];
   endfunction

   // Output side: every sample_cnt step is one emitted result.
   always @(negedge clk) begin
      if (!rst) begin
         prev_cnt = '0;
      end else if (bus.sample_cnt != prev_cnt) begin
         check_eq("cnt_step", {16'h0, bus.sample_cnt}, {16'h0, prev_cnt + 16'd1});
         check_eq("valid_out", {31'h0, bus.valid_out}, 32'h1);
         if (exp_q.size() == 0)
            check_eq("sb_underflow", 32'(exp_q.size()), 32'h1);
         else
            check_eq("y", bus.y, exp_q.pop_front());
         prev_cnt = bus.sample_cnt;
      end
   end

   task automatic step(input logic e, input logic v, input logic [31:0] av,
                       input logic [31:0] gv, input logic [31:0] exp);
      @(negedge clk);
      bus.en = e; bus.valid_in = v; bus.a = av; bus.g = gv;
      if (e && v) exp_q.push_back(exp);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
      idle(2);
      check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
   endtask

   logic [31:0] sy;
   logic        sv;
   logic [15:0] sc, base;
   logic [31:0] ra, rg;

   initial begin
      bus.en = 1'b0; bus.valid_in = 1'b0; bus.a = '0; bus.g = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_y", bus.y, 32'h0);
      check_eq("rst_vout", {31'h0, bus.valid_out}, 32'h0);
      check_eq("rst_cnt", {16'h0, bus.sample_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Reset mid-stream: sample 2 accepted, then reset during the next cycle.
      step(1'b1, 1'b1, 32'h00800000, 32'h01000000, 32'h00400000);
      step(1'b1, 1'b1, 32'h00800000, 32'h01000000, 32'h00400000);
      step(1'b1, 1'b1, 32'h00800000, 32'h01000000, 32'h00400000);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      check_eq("mid_rst_y", bus.y, 32'h0);
      check_eq("mid_rst_vout", {31'h0, bus.valid_out}, 32'h0);
      check_eq("mid_rst_cnt", {16'h0, bus.sample_cnt}, 32'h0);
      @(negedge clk);
      bus.valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(6);
      check_eq("no_stale_vout", {31'h0, bus.valid_out}, 32'h0);
      check_eq("no_stale_cnt", {16'h0, bus.sample_cnt}, 32'h0);

      // Directed vectors
      step(1'b1, 1'b1, 32'h00800000, 32'h01000000, 32'h00400000);
      drain();
      check_eq("first_cnt", {16'h0, bus.sample_cnt}, 32'h1);
      step(1'b1, 1'b1, 32'h00800000, 32'hFE000000, 32'hFF800000);
      step(1'b1, 1'b1, 32'h00000000, 32'h01000000, 32'h00000000);
      step(1'b1, 1'b1, 32'h01000000, 32'h01000000, 32'h00000000);
      step(1'b1, 1'b1, 32'h01800000, 32'h01000000, 32'h00000000);
      step(1'b1, 1'b1, 32'hFFC00000, 32'h01000000, 32'h00000000);
`ifdef SIGMOID_GRAD_ROUND_EN
      step(1'b1, 1'b1, 32'h00000001, 32'h01000000, 32'h00000001);
`else
      step(1'b1, 1'b1, 32'h00000001, 32'h01000000, 32'h00000000);
`endif
      drain();

      // Stall: two samples in, five frozen cycles with junk offered, two more in.
      base = bus.sample_cnt;
      step(1'b1, 1'b1, 32'h00400000, 32'h02000000, model(32'h00400000, 32'h02000000));
      step(1'b1, 1'b1, 32'h00C00000, 32'hFF000000, model(32'h00C00000, 32'hFF000000));
      #1;
      sy = bus.y; sv = bus.valid_out; sc = bus.sample_cnt;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 32'h00800000, 32'h7FFFFFFF, 32'h0);
         #1;
         check_eq("stall_y", bus.y, sy);
         check_eq("stall_vout", {31'h0, bus.valid_out}, {31'h0, sv});
         check_eq("stall_cnt", {16'h0, bus.sample_cnt}, {16'h0, sc});
      end
      step(1'b1, 1'b1, 32'h00200000, 32'h00800000, model(32'h00200000, 32'h00800000));
      step(1'b1, 1'b1, 32'h00E00000, 32'hF0000000, model(32'h00E00000, 32'hF0000000));
      drain();
      check_eq("stall_cnt_end", {16'h0, bus.sample_cnt}, {16'h0, base + 16'd4});

      // Random traffic with random enable gaps
      for (int i = 0; i < 40; i++) begin
         ra = $urandom_range(0, 32'h01400000) - 32'h00200000;
         rg = $urandom;
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rg, model(ra, rg));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
